// File: rtl/abro_cond_pkg.sv
// Shared types and constants for the ABRO input conditioner.
package abro_cond_pkg;

  typedef enum logic [1:0] {
    DB_LOW  = 2'b00,
    DB_RISE = 2'b01,
    DB_HIGH = 2'b10,
    DB_FALL = 2'b11
  } db_state_t;

  localparam int              GLITCH_CNT_W   = 8;
  localparam logic [7:0]      GLITCH_CNT_MAX = 8'hFF;

endpackage

// File: rtl/abro_debounce_ch.sv
// One conditioning channel: synchroniser chain, debounce FSM with qualifying
// counter, registered rising-edge pulse.
// Optional: ABRO_COND_GLITCH_CNT_EN adds a saturating count of aborted
// transitions, exported on glitch_cnt.
//
// state   | meaning
// DB_LOW  | debounced level 0, input agrees
// DB_RISE | input went 1, counting consecutive 1 samples
// DB_HIGH | debounced level 1, input agrees
// DB_FALL | input went 0, counting consecutive 0 samples
module abro_debounce_ch
  import abro_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
`ifdef ABRO_COND_GLITCH_CNT_EN
  output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
  output logic lvl,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  db_state_t              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   lvl_q;
  logic                   rise_q;

  assign sync = sync_q[SYNC_STAGES-1];

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Debounce FSM; level and pulse are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DB_LOW;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      unique case (state_q)
        DB_LOW: begin
          if (sync) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= DB_HIGH;
              lvl_q   <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              state_q <= DB_RISE;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        DB_RISE: begin
          if (!sync) begin
            state_q <= DB_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_HIGH;
            cnt_q   <= '0;
            lvl_q   <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DB_HIGH: begin
          if (!sync) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_q <= DB_LOW;
              lvl_q   <= 1'b0;
            end else begin
              state_q <= DB_FALL;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        DB_FALL: begin
          if (sync) begin
            state_q <= DB_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_LOW;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= DB_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign lvl  = lvl_q;
  assign rise = rise_q;

`ifdef ABRO_COND_GLITCH_CNT_EN
  logic                    abort;
  logic [GLITCH_CNT_W-1:0] glitch_q;
  logic [GLITCH_CNT_W-1:0] glitch_d;

  // An abort is the input reverting before the qualifying count completes.
  always_comb begin
    abort    = ((state_q == DB_RISE) && !sync) || ((state_q == DB_FALL) && sync);
    glitch_d = glitch_q;
    if (abort && (glitch_q != GLITCH_CNT_MAX)) glitch_d = glitch_q + 8'd1;
  end

  // Saturating glitch counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) glitch_q <= '0;
    else       glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: rtl/abro_input_conditioner.sv
// Front-end for the ABRO FSM: three conditioned channels (A, B, restart R).
// A restart pulse suppresses the A/B rise pulses in the same cycle so the
// FSM never sees a restart and an event together; levels pass untouched.
// Optional: ABRO_COND_GLITCH_CNT_EN exports per-channel glitch counters.
module abro_input_conditioner
  import abro_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  input  logic r_raw,
`ifdef ABRO_COND_GLITCH_CNT_EN
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_a,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_b,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_r,
`endif
  output logic a_lvl,
  output logic b_lvl,
  output logic a_rise,
  output logic b_rise,
  output logic r_pulse
);

  logic a_rise_ch;
  logic b_rise_ch;
  logic r_lvl_unused;

  abro_debounce_ch #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
  ) u_ch_a (
    .clk(clk), .reset(reset), .raw(a_raw),
`ifdef ABRO_COND_GLITCH_CNT_EN
    .glitch_cnt(glitch_cnt_a),
`endif
    .lvl(a_lvl), .rise(a_rise_ch)
  );

  abro_debounce_ch #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
  ) u_ch_b (
    .clk(clk), .reset(reset), .raw(b_raw),
`ifdef ABRO_COND_GLITCH_CNT_EN
    .glitch_cnt(glitch_cnt_b),
`endif
    .lvl(b_lvl), .rise(b_rise_ch)
  );

  abro_debounce_ch #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
  ) u_ch_r (
    .clk(clk), .reset(reset), .raw(r_raw),
`ifdef ABRO_COND_GLITCH_CNT_EN
    .glitch_cnt(glitch_cnt_r),
`endif
    .lvl(r_lvl_unused), .rise(r_pulse)
  );

  // Restart has priority over A/B events in the same cycle.
  always_comb begin
    a_rise = a_rise_ch & ~r_pulse;
    b_rise = b_rise_ch & ~r_pulse;
  end

endmodule

// File: tb/tb_abro_input_conditioner.sv
// Self-checking bench for abro_input_conditioner (default parameters).
// Expected output vectors {a_lvl,b_lvl,a_rise,b_rise,r_pulse} are queued as
// stimulus is applied and popped one per clock edge.
module tb_abro_input_conditioner;

  logic clk, reset, a_raw, b_raw, r_raw;
  logic a_lvl, b_lvl, a_rise, b_rise, r_pulse;
`ifdef ABRO_COND_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_a, glitch_cnt_b, glitch_cnt_r;
`endif

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];
  logic [4:0] got, exp_v;

  abro_input_conditioner dut (
    .clk(clk), .reset(reset), .a_raw(a_raw), .b_raw(b_raw), .r_raw(r_raw),
`ifdef ABRO_COND_GLITCH_CNT_EN
    .glitch_cnt_a(glitch_cnt_a), .glitch_cnt_b(glitch_cnt_b), .glitch_cnt_r(glitch_cnt_r),
`endif
    .a_lvl(a_lvl), .b_lvl(b_lvl), .a_rise(a_rise), .b_rise(b_rise), .r_pulse(r_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b1; a_raw = 1'b0; b_raw = 1'b0; r_raw = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; a_raw = 1'b1; b_raw = 1'b1; r_raw = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(negedge clk);
      got = {a_lvl, b_lvl, a_rise, b_rise, r_pulse};
      checks++;
      if (got !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs edge %0d got %b expected 00000", e, got);
      end
`ifdef ABRO_COND_GLITCH_CNT_EN
      checks++;
      if ({glitch_cnt_a, glitch_cnt_b, glitch_cnt_r} !== 24'h0) begin
        errors++;
        $display("FAIL reset_glitch got %h expected 000000", {glitch_cnt_a, glitch_cnt_b, glitch_cnt_r});
      end
`endif
    end
    reset = 1'b0;
    for (int e = 1; e <= 8; e++)
      exp_q.push_back({e >= 6, e >= 6, 1'b0, 1'b0, e == 6});
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      got = {a_lvl, b_lvl, a_rise, b_rise, r_pulse};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL reset_release edge %0d got %b expected %b", e, got, exp_v);
      end
    end
  endtask

  task automatic test_a_rise_fall();
    apply_reset();
    a_raw = 1'b1;
    for (int e = 1; e <= 12; e++)
      exp_q.push_back({e >= 6, 1'b0, e == 6, 1'b0, 1'b0});
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      got = {a_lvl, b_lvl, a_rise, b_rise, r_pulse};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL a_rise edge %0d got %b expected %b", e, got, exp_v);
      end
    end
    a_raw = 1'b0;
    for (int e = 1; e <= 8; e++)
      exp_q.push_back({e < 6, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      got = {a_lvl, b_lvl, a_rise, b_rise, r_pulse};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL a_fall edge %0d got %b expected %b", e, got, exp_v);
      end
    end
  endtask

  task automatic test_b_glitch();
    apply_reset();
    b_raw = 1'b1;
    for (int e = 1; e <= 12; e++) exp_q.push_back(5'b0);
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (e == 3) b_raw = 1'b0;
      got = {a_lvl, b_lvl, a_rise, b_rise, r_pulse};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL b_glitch edge %0d got %b expected %b", e, got, exp_v);
      end
    end
`ifdef ABRO_COND_GLITCH_CNT_EN
    checks++;
    if ({glitch_cnt_a, glitch_cnt_b, glitch_cnt_r} !== {8'd0, 8'd1, 8'd0}) begin
      errors++;
      $display("FAIL glitch_cnt got a=%0d b=%0d r=%0d expected a=0 b=1 r=0",
               glitch_cnt_a, glitch_cnt_b, glitch_cnt_r);
    end
`endif
  endtask

  task automatic test_back_to_back();
    apply_reset();
    a_raw = 1'b1; b_raw = 1'b1;
    for (int e = 1; e <= 8; e++)
      exp_q.push_back({e >= 6, e >= 6, e == 6, e == 6, 1'b0});
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      got = {a_lvl, b_lvl, a_rise, b_rise, r_pulse};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL ab_together edge %0d got %b expected %b", e, got, exp_v);
      end
    end
  endtask

  task automatic test_r_priority();
    apply_reset();
    a_raw = 1'b1; r_raw = 1'b1;
    for (int e = 1; e <= 8; e++)
      exp_q.push_back({e >= 6, 1'b0, 1'b0, 1'b0, e == 6});
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      got = {a_lvl, b_lvl, a_rise, b_rise, r_pulse};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL r_priority edge %0d got %b expected %b", e, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    apply_reset();
    a_raw = 1'b1;
    // Reset is sampled at edge 4; the delay restarts from edge 5.
    for (int e = 1; e <= 12; e++) begin
      if (e <= 4) exp_q.push_back(5'b0);
      else        exp_q.push_back({(e - 4) >= 6, 1'b0, (e - 4) == 6, 1'b0, 1'b0});
    end
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (e == 3) reset = 1'b1;
      if (e == 4) reset = 1'b0;
      got = {a_lvl, b_lvl, a_rise, b_rise, r_pulse};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL reset_mid edge %0d got %b expected %b", e, got, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1'b1; a_raw = 1'b0; b_raw = 1'b0; r_raw = 1'b0;
    test_reset();
    test_a_rise_fall();
    test_b_glitch();
    test_back_to_back();
    test_r_priority();
    test_reset_mid_debounce();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
